// File: rtl/tf_data_pair9.sv
// tf_data_pair9: stage-9 twiddle/data pairing buffer.
// Requests twiddles from the stage-9 provider and buffers them in one FIFO.
// Buffers butterfly samples in a second FIFO.
// Emits aligned {data, twiddle} pairs with ready/valid flow control.
// The last pair of every TF_NUM-pair frame is tagged with frame_last.
//
// Ports:
//   clk            - rising-edge clock
//   rst            - asynchronous active-low reset
//   data_in        - butterfly sample {re,im}
//   data_in_valid  - qualifies data_in
//   data_in_ready  - data FIFO not full
//   tf_en          - twiddle request to provider
//   tf_in          - twiddle {re,im}, returned one cycle after tf_en
//   tf_in_valid    - qualifies tf_in
//   data_out       - paired sample
//   tf_out         - paired twiddle
//   data_out_valid - qualifies the output pair
//   out_ready      - downstream accepts the pair
//   frame_last     - marks the pair with index TF_NUM-1
//   err_ovf        - sticky overflow flag
//
// Optional feature: define TFPAIR_OVF_CHECK_EN to enable overflow
// detection on err_ovf. Without it, err_ovf is tied low and
// offending words are dropped silently.

module tf_data_pair9 #(
    parameter int FLOAT_LEN     = 32,
    parameter int TF_NUM        = 256,
    parameter int TF_IDX_LEN    = 8,
    parameter int FIFO_ADDR_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*FLOAT_LEN-1:0] data_in,
    input  logic                   data_in_valid,
    output logic                   data_in_ready,
    output logic                   tf_en,
    input  logic [2*FLOAT_LEN-1:0] tf_in,
    input  logic                   tf_in_valid,
    output logic [2*FLOAT_LEN-1:0] data_out,
    output logic [2*FLOAT_LEN-1:0] tf_out,
    output logic                   data_out_valid,
    input  logic                   out_ready,
    output logic                   frame_last,
    output logic                   err_ovf
);

    localparam int W     = 2 * FLOAT_LEN;
    localparam int CW    = FIFO_ADDR_LEN + 1;
    localparam int DEPTH = 1 << FIFO_ADDR_LEN;

    localparam logic [CW-1:0] L_DEPTH = CW'(DEPTH);
    localparam logic [TF_IDX_LEN-1:0] L_LAST = TF_IDX_LEN'(TF_NUM - 1);

    // Run flag and in-flight twiddle request
    logic r_run;
    logic r_tf_en_q;

    // Data FIFO
    logic [W-1:0]             r_dmem [DEPTH];
    logic [FIFO_ADDR_LEN-1:0] r_dwr;
    logic [FIFO_ADDR_LEN-1:0] r_drd;
    logic [CW-1:0]            r_dcnt;

    // Twiddle FIFO
    logic [W-1:0]             r_tmem [DEPTH];
    logic [FIFO_ADDR_LEN-1:0] r_twr;
    logic [FIFO_ADDR_LEN-1:0] r_trd;
    logic [CW-1:0]            r_tcnt;

    // Output stage
    logic [W-1:0]            r_data_out;
    logic [W-1:0]            r_tf_out;
    logic                    r_dov;
    logic                    r_fl;
    logic [TF_IDX_LEN-1:0]   r_pidx;

    logic          w_dready;
    logic          w_dpush;
    logic          w_tpush;
    logic          w_pop;
    logic          w_tf_en;
    logic [CW:0]   w_tsum;

    assign w_dready = (r_dcnt != L_DEPTH);
    assign w_dpush  = data_in_valid & w_dready;
    assign w_tpush  = tf_in_valid & (r_tcnt != L_DEPTH);

    assign w_pop = (r_dcnt != '0) & (r_tcnt != '0)
                 & (~r_dov | out_ready);

    // Credit: buffered twiddles plus the one possibly in flight
    // must leave room for the next response.
    assign w_tsum  = {1'b0, r_tcnt} + {{CW{1'b0}}, r_tf_en_q};
    assign w_tf_en = r_run & (w_tsum < {1'b0, L_DEPTH});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run     <= 1'b0;
            r_tf_en_q <= 1'b0;
        end else begin
            r_run     <= 1'b1;
            r_tf_en_q <= w_tf_en;
        end
    end

    // FIFO storage carries no reset; pointers and counts gate its use
    always_ff @(posedge clk) begin
        if (w_dpush) begin
            r_dmem[r_dwr] <= data_in;
        end
        if (w_tpush) begin
            r_tmem[r_twr] <= tf_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dwr  <= '0;
            r_drd  <= '0;
            r_dcnt <= '0;
        end else begin
            if (w_dpush) begin
                r_dwr <= r_dwr + 1'b1;
            end
            if (w_pop) begin
                r_drd <= r_drd + 1'b1;
            end
            case ({w_dpush, w_pop})
                2'b10:   r_dcnt <= r_dcnt + 1'b1;
                2'b01:   r_dcnt <= r_dcnt - 1'b1;
                default: r_dcnt <= r_dcnt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_twr  <= '0;
            r_trd  <= '0;
            r_tcnt <= '0;
        end else begin
            if (w_tpush) begin
                r_twr <= r_twr + 1'b1;
            end
            if (w_pop) begin
                r_trd <= r_trd + 1'b1;
            end
            case ({w_tpush, w_pop})
                2'b10:   r_tcnt <= r_tcnt + 1'b1;
                2'b01:   r_tcnt <= r_tcnt - 1'b1;
                default: r_tcnt <= r_tcnt;
            endcase
        end
    end

    // Output register: loads a new pair, clears when drained,
    // holds while the pair is valid but not accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_data_out <= '0;
            r_tf_out   <= '0;
            r_dov      <= 1'b0;
            r_fl       <= 1'b0;
            r_pidx     <= '0;
        end else if (w_pop) begin
            r_data_out <= r_dmem[r_drd];
            r_tf_out   <= r_tmem[r_trd];
            r_dov      <= 1'b1;
            r_fl       <= (r_pidx == L_LAST);
            r_pidx     <= r_pidx + 1'b1;
        end else if (out_ready) begin
            r_dov <= 1'b0;
            r_fl  <= 1'b0;
        end
    end

`ifdef TFPAIR_OVF_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if ((data_in_valid & ~w_dready)
                   | (tf_in_valid & (r_tcnt == L_DEPTH))) begin
            r_err <= 1'b1;
        end
    end

    assign err_ovf = r_err;
`else
    assign err_ovf = 1'b0;
`endif

    assign data_in_ready  = w_dready;
    assign tf_en          = w_tf_en;
    assign data_out       = r_data_out;
    assign tf_out         = r_tf_out;
    assign data_out_valid = r_dov;
    assign frame_last     = r_fl;

endmodule

// File: tb/tb_tf_data_pair9.sv
// tb_tf_data_pair9: directed bench for tf_data_pair9.
// Includes a twiddle provider model and an in-order pair monitor.

module tb_tf_data_pair9;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
    logic        data_in_valid;
    logic        data_in_ready;
    logic        tf_en;
    logic [63:0] tf_in;
    logic        tf_in_valid;
    logic [63:0] data_out;
    logic [63:0] tf_out;
    logic        data_out_valid;
    logic        out_ready;
    logic        frame_last;
    logic        err_ovf;

`ifdef TFPAIR_OVF_CHECK_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    tf_data_pair9 dut (
        .clk            (clk),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .tf_en          (tf_en),
        .tf_in          (tf_in),
        .tf_in_valid    (tf_in_valid),
        .data_out       (data_out),
        .tf_out         (tf_out),
        .data_out_valid (data_out_valid),
        .out_ready      (out_ready),
        .frame_last     (frame_last),
        .err_ovf        (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] tw(input logic [7:0] a);
        return {24'h400000, a, 24'hC00000, a};
    endfunction

    function automatic logic [63:0] mk(input int i);
        return {32'hD0000000 + 32'(i), 32'hE0000000 ^ 32'(i)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Provider: answers each tf_en one cycle later, in address order
    logic [7:0] p_addr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            tf_in_valid <= 1'b0;
            tf_in       <= '0;
            p_addr      <= '0;
        end else begin
            tf_in_valid <= tf_en;
            if (tf_en) begin
                tf_in  <= tw(p_addr);
                p_addr <= p_addr + 8'd1;
            end
        end
    end

    // Monitor: every accepted pair must match the next accepted sample
    // and the twiddle of its index; frame_last only on index 255.
    logic [63:0] expq[$];
    logic [63:0] ed;
    logic [7:0]  pidx;
    int          pair_cnt;
    int          fl_cnt;

    always @(negedge clk) begin
        if (!rst) begin
            expq.delete();
            pidx     = 8'd0;
            pair_cnt = 0;
            fl_cnt   = 0;
        end else begin
            if (data_in_valid && data_in_ready) begin
                expq.push_back(data_in);
            end
            if (data_out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    chk("pair_extra", 64'(expq.size()), 64'd1);
                end else begin
                    ed = expq.pop_front();
                    chk("pair_data", data_out, ed);
                    chk("pair_tf", tf_out, tw(pidx));
                    chk("pair_last", 64'(frame_last),
                        64'(pidx == 8'd255));
                    if (frame_last) fl_cnt++;
                    pidx = pidx + 8'd1;
                    pair_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [63:0] d);
        bit ok;
        int n;
        data_in       = d;
        data_in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = data_in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        data_in_valid = 1'b0;
        if (!ok) chk("send_ready", 64'(ok), 64'd1);
    endtask

    initial begin
        int          n;
        int          acc;
        int          chg;
        bit          ok;
        bit          have;
        logic [63:0] hold;

        rst           = 1'b0;
        data_in       = '0;
        data_in_valid = 1'b0;
        out_ready     = 1'b1;

        repeat (3) step();
        chk("rst_dov", 64'(data_out_valid), 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_tf", tf_out, 64'd0);
        chk("rst_last", 64'(frame_last), 64'd0);
        chk("rst_tfen", 64'(tf_en), 64'd0);
        chk("rst_ovf", 64'(err_ovf), 64'd0);
        chk("rst_ready", 64'(data_in_ready), 64'd1);

        // Release: tf_en rises after run sets, stops at 8 credits
        rst = 1'b1;
        chk("rel_tfen0", 64'(tf_en), 64'd0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (tf_en) n++;
        end
        chk("t1_tfen_cycles", 64'(n), 64'd8);
        chk("t1_tfen_low", 64'(tf_en), 64'd0);
        chk("t1_no_pair", 64'(data_out_valid), 64'd0);

        // Single sample: pair appears two cycles after acceptance
        data_in       = 64'h3F800000_00000000;
        data_in_valid = 1'b1;
        step();
        data_in_valid = 1'b0;
        chk("t2_c1_dov", 64'(data_out_valid), 64'd0);
        step();
        chk("t2_dov", 64'(data_out_valid), 64'd1);
        chk("t2_data", data_out, 64'h3F800000_00000000);
        chk("t2_tf", tf_out, 64'h40000000_C0000000);
        chk("t2_last", 64'(frame_last), 64'd0);
        step();
        chk("t2_dov_clr", 64'(data_out_valid), 64'd0);
        repeat (5) step();

        // 256 back-to-back samples
        for (int i = 0; i < 256; i++) send(mk(i));
        repeat (12) step();
        chk("t3_drained", 64'(expq.size()), 64'd0);
        chk("t3_pairs", 64'(pair_cnt), 64'd257);
        chk("t3_frame_last", 64'(fl_cnt), 64'd1);

        // Backpressure for 20 cycles: 1 held pair + 8 buffered
        out_ready     = 1'b0;
        acc           = 0;
        chg           = 0;
        have          = 1'b0;
        hold          = '0;
        data_in_valid = 1'b1;
        data_in       = mk(1000);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            ok = data_in_ready;
            if (data_out_valid) begin
                if (!have) begin
                    hold = data_out;
                    have = 1'b1;
                end else if (data_out !== hold) begin
                    chg++;
                end
            end
            step();
            if (ok) begin
                acc++;
                data_in = mk(1000 + acc);
            end
        end
        data_in_valid = 1'b0;
        chk("t4_accepted", 64'(acc), 64'd9);
        chk("t4_changes", 64'(chg), 64'd0);
        chk("t4_hold", hold, mk(1000));
        chk("t4_ready_low", 64'(data_in_ready), 64'd0);
        chk("t4_dov_held", 64'(data_out_valid), 64'd1);
        out_ready = 1'b1;
        repeat (15) step();
        chk("t4_drained", 64'(expq.size()), 64'd0);
        chk("t4_pairs", 64'(pair_cnt), 64'd266);

        // Overflow attempt while full
        chk("t5_ovf_before", 64'(err_ovf), 64'd0);
        out_ready     = 1'b0;
        acc           = 0;
        data_in_valid = 1'b1;
        data_in       = mk(2000);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            ok = data_in_ready;
            step();
            if (ok) begin
                acc++;
                data_in = mk(2000 + acc);
            end
        end
        data_in_valid = 1'b0;
        chk("t5_accepted", 64'(acc), 64'd9);
        chk("t5_ovf", 64'(err_ovf), 64'(EXP_OVF));
        out_ready = 1'b1;
        repeat (15) step();
        chk("t5_ovf_sticky", 64'(err_ovf), 64'(EXP_OVF));
        chk("t5_drained", 64'(expq.size()), 64'd0);
        chk("t5_pairs", 64'(pair_cnt), 64'd275);

        // Mid-frame reset with a pair held at the output
        for (int i = 0; i < 100; i++) send(mk(3000 + i));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(mk(3100 + i));
        repeat (2) step();
        chk("t6_pre_dov", 64'(data_out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_dov", 64'(data_out_valid), 64'd0);
        chk("t6_data", data_out, 64'd0);
        chk("t6_tf", tf_out, 64'd0);
        chk("t6_last", 64'(frame_last), 64'd0);
        chk("t6_tfen", 64'(tf_en), 64'd0);
        chk("t6_ovf", 64'(err_ovf), 64'd0);
        chk("t6_ready", 64'(data_in_ready), 64'd1);
        repeat (3) step();
        rst       = 1'b1;
        out_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 256; i++) send(mk(4000 + i));
        repeat (12) step();
        chk("t6_drained", 64'(expq.size()), 64'd0);
        chk("t6_pairs", 64'(pair_cnt), 64'd256);
        chk("t6_frame_last", 64'(fl_cnt), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
